// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller
//
// Control unit for the multicycle MIPS datapath. It decodes op/funct and
// steps through fetch, decode, execute, memory and writeback. It drives every
// datapath enable and mux select. Each memory-access state can stall for a
// configurable number of extra cycles, so a slower unified memory can sit
// behind the same datapath.
//
// Parameters:
//   MEM_WAIT    extra stall cycles in FETCH, MEMRD and MEMWR (0..15)
//
// Optional feature (compile-time macro):
//   MIPS_BNE_EN adds bne (op 000101). When the macro is not defined, bne
//               decodes as an illegal opcode.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous reset, active low (0 = reset)
//   op, funct   instruction fields from the instruction register
//   zero        ALU zero flag
//   pcen        PC register enable
//   memwrite    memory write strobe
//   irwrite     instruction register enable
//   regwrite    register file write enable
//   iord        memory address select (1 = ALUOut)
//   memtoreg    writeback select (1 = data register)
//   regdst      destination register select (1 = rd)
//   alusrca     ALU A select (1 = register A)
//   alusrcb     ALU B select: 00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc       next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target
//   alucontrol  ALU operation
//   illegal     one-cycle pulse in DECODE on an unsupported opcode
// ---------------------------------------------------------------------------
module mips_multicycle_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
`ifdef MIPS_BNE_EN
    , BNEEX
`endif
  } state_t;

  state_t     state, next_state, eff_state;
  logic [3:0] wait_cnt;
  logic       wait_done, access_state;
  logic       pcwrite, branch, bne;
  logic       irwrite_s, regwrite_s, memwrite_s, illegal_s;
  logic [1:0] aluop;

  assign wait_done    = (wait_cnt == WAIT_MAX);
  assign access_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  // State register plus stall counter. The counter only runs in the access
  // states and clears as soon as the state moves on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (access_state && !wait_done)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Next state and Moore outputs. While reset is held, decode as FETCH so the
  // mux selects show their fetch values. All enables are then masked below.
  always_comb begin
    eff_state  = reset ? state : FETCH;
    next_state = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;

    case (eff_state)
      FETCH: begin
        alusrcb = 2'b01;
        if (wait_done) begin
          irwrite_s  = 1'b1;
          pcwrite    = 1'b1;
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       next_state = BNEEX;
`endif
          default: begin
            illegal_s  = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = wait_done ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = wait_done;
        next_state = wait_done ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        next_state = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MIPS_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne     = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    irwrite  = reset & irwrite_s;
    regwrite = reset & regwrite_s;
    memwrite = reset & memwrite_s;
    illegal  = reset & illegal_s;
`ifdef MIPS_BNE_EN
    pcen = reset & (pcwrite | (branch & zero) | (bne & ~zero));
`else
    pcen = reset & (pcwrite | (branch & zero) | (bne & 1'b0));
`endif
  end

  // ALU decoder. For R-type instructions, an unknown funct falls back to add.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath inside top.
- Decodes op/funct and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, including memwrite, the signal the system bench watches to check stores.
- Adds configurable memory wait states so a slower unified memory can be used without changing the datapath.

Parameters:
- MEM_WAIT, 0: extra stall cycles in each memory-access state (FETCH, MEMRD, MEMWR), range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address select (1 = ALUOut)
- memtoreg  out  1  writeback select (1 = data register)
- regdst  out  1  destination select (1 = rd)
- alusrca  out  1  ALU A select (1 = register A)
- alusrcb  out  2  ALU B select: 00 B, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target
- alucontrol  out  3  ALU operation
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Moore FSM, registered state plus a 4-bit wait counter. Outputs decode from current state; pcen and alucontrol are also combinational on zero, op and funct.
- Reset:
  - reset==0 at a posedge: state<=FETCH, counter<=0.
  - While reset==0, pcen, irwrite, regwrite, memwrite and illegal are forced 0 combinationally.
  - Mux selects take their FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
- Reset mid-instruction abandons it; no write enable is issued after the reset edge.
- States, their outputs (all unlisted enables 0, selects 0) and transitions:
  - FETCH: alusrcb=01, aluop=00; irwrite and pcwrite only on the final wait cycle. -> DECODE
  - DECODE: alusrcb=11. Next state by op:
    - 100011/101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other opcode: illegal=1 -> FETCH
  - MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1. -> MEMWB
  - MEMWB: memtoreg=1, regwrite=1. -> FETCH
  - MEMWR: iord=1; memwrite=1 only on the final wait cycle. -> FETCH
  - RTYPEEX: alusrca=1, aluop=10. -> RTYPEWB
  - RTYPEWB: regdst=1, regwrite=1. -> FETCH
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. -> FETCH
  - ADDIEX: alusrca=1, alusrcb=10. -> ADDIWB
  - ADDIWB: regwrite=1. -> FETCH
  - JEX: pcsrc=10, pcwrite=1. -> FETCH
- Wait states:
  - In FETCH, MEMRD and MEMWR the counter counts 0..MEM_WAIT; the state holds until counter==MEM_WAIT, then advances and the counter clears to 0.
  - With MEM_WAIT=0 each of these states lasts exactly 1 cycle.
  - Selects stay stable for the whole stall.
- pcen = pcwrite | (branch & zero).
- Instruction cycle counts at MEM_WAIT=0:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal 2
- Each access state (FETCH, MEMRD, MEMWR) adds MEM_WAIT cycles.
- alucontrol:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 1x -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.

Optional Feature:
- Macro: MIPS_BNE_EN.
- When defined:
  - op 000101 in DECODE -> BNEEX, which drives the same selects as BEQEX.
  - An internal bne flag is set and pcen = pcwrite | (branch & zero) | (bne & ~zero).
- When undefined, 000101 is treated as illegal: illegal pulse, return to FETCH.

Test Plan:
- reset=0 for 3 cycles with op=101011 -> memwrite, pcen, irwrite, regwrite all 0. Release -> FETCH: irwrite=1, pcen=1, alusrcb=01.
- MEM_WAIT=0, op=101011 (sw) -> states FETCH, DECODE, MEMADR, MEMWR; memwrite=1 in cycle 4 only, with iord=1; back in FETCH at cycle 5.
- MEM_WAIT=2, op=100011 (lw) -> FETCH 3 cycles with irwrite=1 only in the 3rd; MEMRD 3 cycles; regwrite=1, memtoreg=1 in MEMWB; total 9 cycles.
- op=000000, funct=101010 -> alucontrol=111 in RTYPEEX; regwrite=1, regdst=1 in RTYPEWB.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BEQEX. Same with zero=0 -> pcen=0.
- op=111111 -> illegal=1 for one cycle in DECODE, return to FETCH, no write enable asserted.
- Under MIPS_BNE_EN, op=000101 with zero=0 -> pcen=1 in BNEEX.
